// File: rtl/dispatcher_1_4_32_pkg.sv
// Shared definitions for the 1-to-4 write-back dispatcher.
//   DISP_CH     : number of consumer channels
//   disp_ch_t   : channel index carried on in_sel
//   CH_*        : conventional channel assignment for write-back sinks
package dispatcher_1_4_32_pkg;

    localparam int DISP_CH = 4;

    typedef logic [1:0] disp_ch_t;

    localparam disp_ch_t CH_REGFILE = 2'd0;
    localparam disp_ch_t CH_HI      = 2'd1;
    localparam disp_ch_t CH_LO      = 2'd2;
    localparam disp_ch_t CH_CP0     = 2'd3;

    // One-hot decode of a channel index.
    function automatic logic [DISP_CH-1:0] ch_onehot(input disp_ch_t ch);
        logic [DISP_CH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dispatcher_1_4_32_dispatch_fifo.sv
// Per-channel synchronous FIFO for the dispatcher.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear; dominates push
//   push        : write push_data (ignored when full or flushing)
//   push_data   : word to write
//   pop         : remove head word (ignored when empty)
//   head_data   : current head word, forced to 0 when empty
//   full, empty : occupancy status
module dispatch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the empty gate on head_data hides stale words.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dispatcher_1_4_32.sv
// 1-to-4 dispatcher: routes one producer stream to four buffered consumer
// channels selected by in_sel. Each channel stalls independently.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : clear all channel FIFOs at the next edge
//   in_valid/in_ready   : producer handshake; in_sel picks the channel
//   in_data             : producer word
//   out_valid/out_ready : per-channel consumer handshake (bit i = channel i)
//   out0..3_data        : per-channel head words (0 when empty)
//   full                : per-channel FIFO full status
module dispatcher_1_4_32
    import dispatcher_1_4_32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [DATA_W-1:0] out1_data,
    output logic [DATA_W-1:0] out2_data,
    output logic [DATA_W-1:0] out3_data,
    output logic [3:0]        full
);

    logic [DISP_CH-1:0] push_vec;
    logic [DISP_CH-1:0] pop_vec;
    logic [DISP_CH-1:0] empty_vec;
    logic [DATA_W-1:0]  head [DISP_CH];

    // Ready looks only at the selected channel, never at out_ready, so a
    // slot freed by a same-cycle pop is not reused until the next cycle.
    assign in_ready = !flush && !full[in_sel];
    assign push_vec = (in_valid && in_ready) ? ch_onehot(disp_ch_t'(in_sel)) : '0;
    assign pop_vec  = out_valid & out_ready;

    for (genvar i = 0; i < DISP_CH; i++) begin : g_ch
        dispatch_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push_vec[i]),
            .push_data (in_data),
            .pop       (pop_vec[i]),
            .head_data (head[i]),
            .full      (full[i]),
            .empty     (empty_vec[i])
        );
    end

    assign out_valid = ~empty_vec;
    assign out0_data = head[CH_REGFILE];
    assign out1_data = head[CH_HI];
    assign out2_data = head[CH_LO];
    assign out3_data = head[CH_CP0];

endmodule

// File: tb/tb_dispatcher_1_4_32.sv
module tb_dispatcher_1_4_32;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out0_data;
    logic [31:0] out1_data;
    logic [31:0] out2_data;
    logic [31:0] out3_data;
    logic [3:0]  full;

    int errors = 0;
    int checks = 0;

    dispatcher_1_4_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch_data(input int ch);
        case (ch)
            0:       return out0_data;
            1:       return out1_data;
            2:       return out2_data;
            default: return out3_data;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 4'b0000 || full !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: out_valid=%b full=%b, required 0000/0000", out_valid, full);
        end
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 32'hDEAD0000);
        tick();
        drive(1'b1, 2'd1, 32'hDEAD0001);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (out_valid !== 4'b0011) begin
            errors++;
            $display("FAIL reset_prefill: out_valid=%b, required 0011", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || full !== 4'b0000 || out0_data !== 32'h0 ||
            out1_data !== 32'h0 || out2_data !== 32'h0 || out3_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b full=%b d0=%h d1=%h, required all zero",
                     out_valid, full, out0_data, out1_data);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 32'h11111111);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (out_valid !== 4'b0100 || out2_data !== 32'h11111111) begin
            errors++;
            $display("FAIL reset_first_push: out_valid=%b d2=%h, required 0100/11111111",
                     out_valid, out2_data);
        end
        out_ready = 4'b1111;
        tick();
    endtask

    task automatic test_routing();
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'hA0 + 32'(i));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL route_ready[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== (4'b0001 << i) || ch_data(i) !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL route_ch[%0d]: out_valid=%b data=%h, required %b/%h",
                         i, out_valid, ch_data(i), 4'b0001 << i, 32'hA0 + 32'(i));
            end
        end
        drive(1'b0, 2'd0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL route_drain: out_valid=%b, required 0000", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 32'hB0);
        tick();
        drive(1'b1, 2'd1, 32'hB1);
        tick();
        checks++;
        if (full !== 4'b0010 || out1_data !== 32'hB0) begin
            errors++;
            $display("FAIL bp_full: full=%b d1=%h, required 0010/000000b0", full, out1_data);
        end
        drive(1'b1, 2'd3, 32'hC3);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready: in_ready=%b, required 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b1010 || out3_data !== 32'hC3) begin
            errors++;
            $display("FAIL bp_other_deliver: out_valid=%b d3=%h, required 1010/000000c3",
                     out_valid, out3_data);
        end
        drive(1'b1, 2'd1, 32'hB2);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_refuse: in_ready=%b, required 0", in_ready);
        end
        tick();
        checks++;
        if (out1_data !== 32'hB0 || full[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: d1=%h full1=%b, required 000000b0/1", out1_data, full[1]);
        end
        out_ready = 4'b1111;
        tick();
        checks++;
        if (out1_data !== 32'hB1 || full[1] !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop0: d1=%h full1=%b in_ready=%b, required 000000b1/0/1",
                     out1_data, full[1], in_ready);
        end
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (out1_data !== 32'hB2 || out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_pop1: d1=%h out_valid=%b, required 000000b2/0010", out1_data, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b, required 0000", out_valid);
        end
    endtask

    task automatic test_full_simul();
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 32'hD0);
        tick();
        drive(1'b1, 2'd0, 32'hD1);
        tick();
        drive(1'b1, 2'd0, 32'hD2);
        out_ready = 4'b0001;
        #1;
        checks++;
        if (full[0] !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fs_refuse: full0=%b in_ready=%b, required 1/0", full[0], in_ready);
        end
        tick();
        checks++;
        if (out0_data !== 32'hD1 || full[0] !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fs_pop: d0=%h full0=%b in_ready=%b, required 000000d1/0/1",
                     out0_data, full[0], in_ready);
        end
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (out0_data !== 32'hD2 || out_valid !== 4'b0001) begin
            errors++;
            $display("FAIL fs_order: d0=%h out_valid=%b, required 000000d2/0001", out0_data, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL fs_drain: out_valid=%b, required 0000", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 32'hE0);
        tick();
        drive(1'b1, 2'd0, 32'hE1);
        tick();
        drive(1'b1, 2'd2, 32'hF0);
        tick();
        drive(1'b1, 2'd2, 32'hF1);
        tick();
        checks++;
        if (full !== 4'b0101 || out_valid !== 4'b0101) begin
            errors++;
            $display("FAIL flush_prefill: full=%b out_valid=%b, required 0101/0101", full, out_valid);
        end
        flush = 1'b1;
        drive(1'b1, 2'd3, 32'h33);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (out_valid !== 4'b0000 || full !== 4'b0000 || out3_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%b full=%b d3=%h in_ready=%b, required 0000/0000/0/1",
                     out_valid, full, out3_data, in_ready);
        end
    endtask

    task automatic test_wrap();
        int bad_full;
        bad_full = 0;
        out_ready = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd2, 32'(i));
            tick();
            if (full !== 4'b0000) bad_full++;
            checks++;
            if (out_valid !== 4'b0100 || out2_data !== 32'(i)) begin
                errors++;
                $display("FAIL wrap_word[%0d]: out_valid=%b d2=%h, required 0100/%h",
                         i, out_valid, out2_data, 32'(i));
            end
        end
        drive(1'b0, 2'd0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 4'b0000 || full !== 4'b0000 || bad_full != 0) begin
            errors++;
            $display("FAIL wrap_end: out_valid=%b full=%b full_seen=%0d, required 0000/0000/0",
                     out_valid, full, bad_full);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b0000;
        #12;
        test_reset_hold: begin
            checks++;
            if (out0_data !== 32'h0 || out3_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_data: d0=%h d3=%h, required 0/0", out0_data, out3_data);
            end
        end
        #5;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_routing();
        test_back_pressure();
        test_full_simul();
        test_flush();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
